dot_product_accumulator: RTL

- Downstream consumer of the 32x32 unsigned Wallace-tree multiplier's 64-bit product `z`.
- Accumulates a programmed number of products into a wide accumulator and presents the sum on a valid/ready output.
- Registers the combinational multiplier output at the clock edge, which gives the datapath its first sequential boundary.

---
 rtl/mac_pkg.sv | 15 +
 rtl/acc_add_sat.sv | 40 ++++
 rtl/dot_product_accumulator.sv | 122 ++++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// Shared definitions for the dot-product accumulator slice:
// the FSM state encoding and the default datapath widths.
package mac_pkg;

  localparam int PROD_W_DEF = 64;
  localparam int ACC_W_DEF  = 72;
  localparam int LEN_W_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/acc_add_sat.sv
// Combinational accumulate step: acc + zero-extended prod, returning the
// next accumulator value and the carry out of bit ACC_W-1.
// Build option: define ACC_SATURATE_EN to clamp the accumulator to all-ones
// on carry-out; it then stays clamped while 'clamped' is high. Without the
// macro the sum wraps modulo 2^ACC_W.
module acc_add_sat #(
  parameter int PROD_W = 64,
  parameter int ACC_W  = 72
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [PROD_W-1:0] prod,
  input  logic              clamped,
  output logic [ACC_W-1:0]  sum,
  output logic              carry
);

  logic [ACC_W:0] wide_sum;

  // Unsigned add one bit wider than the accumulator so the carry is visible.
  always_comb begin
    wide_sum = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};
    carry    = wide_sum[ACC_W];
`ifdef ACC_SATURATE_EN
    if (carry || clamped) begin
      sum = {ACC_W{1'b1}};
    end else begin
      sum = wide_sum[ACC_W-1:0];
    end
`else
    sum = wide_sum[ACC_W-1:0];
`endif
  end

`ifndef ACC_SATURATE_EN
  // The clamp request only matters in saturating builds.
  logic unused_clamped;
  assign unused_clamped = clamped;
`endif

endmodule

// File: rtl/dot_product_accumulator.sv
// Dot-product accumulator: sums a programmed number of multiplier products
// into a wide accumulator and offers the result on a valid/ready output.
// Build option: ACC_SATURATE_EN selects saturating accumulation (see
// acc_add_sat); the default build wraps.
//
// Handshake: a product beat transfers on a cycle where in_valid && in_ready
// at the rising edge; the result transfers on out_valid && out_ready. A
// source may raise valid at any time; ready never depends on valid, and all
// outputs come from registers or the state register only.
module dot_product_accumulator
  import mac_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] prod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              busy,
  output logic              overflow,
  output logic [1:0]        state_dbg
);

  state_t            state;
  state_t            state_next;
  logic [ACC_W-1:0]  acc;
  logic [LEN_W-1:0]  count;
  logic              beat;
  logic [ACC_W-1:0]  add_sum;
  logic              add_carry;

  assign beat = in_valid && (state == ACCUM);

  acc_add_sat #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W)
  ) u_add (
    .acc     (acc),
    .prod    (prod),
    .clamped (overflow),
    .sum     (add_sum),
    .carry   (add_carry)
  );

  // State register; reset abandons any job in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode; start is only looked at in IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (len == '0) ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (beat && (count == LEN_W'(1))) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Accumulator, term counter and sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc      <= '0;
            overflow <= 1'b0;
            count    <= len;
          end
        end
        ACCUM: begin
          if (beat) begin
            acc      <= add_sum;
            overflow <= overflow | add_carry;
            count    <= count - LEN_W'(1);
          end
        end
        default: begin
          acc      <= acc;
          count    <= count;
          overflow <= overflow;
        end
      endcase
    end
  end

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == HOLD);
  assign busy      = (state == ACCUM) || (state == HOLD);
  assign acc_out   = acc;
  assign state_dbg = state;

endmodule
